// File: rtl/concatinator.sv
// 48-to-72 bit little-endian packer (3:2 gearbox) with valid/ready on both sides.
// Optional residue flush port enabled by defining CONCATINATOR_FLUSH_EN.
module concatinator #(
  parameter int unsigned LANE_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*LANE_W-1:0]   a,
  input  logic                  a_valid,
  output logic                  a_ready,
`ifdef CONCATINATOR_FLUSH_EN
  input  logic                  flush,
`endif
  output logic [3*LANE_W-1:0]   b,
  output logic                  b_valid,
  input  logic                  b_ready
);

  // States are named by the number of pending lanes held in the residue.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2*LANE_W-1:0]   residue_q, residue_d;
  logic [3*LANE_W-1:0]   b_q, b_d;
  logic                  b_valid_q, b_valid_d;
  logic                  flush_fire;
  logic                  a_fire;
  logic                  b_fire;

`ifdef CONCATINATOR_FLUSH_EN
  assign flush_fire = flush && (state_q != S0) && (!b_valid_q || b_ready);
`else
  assign flush_fire = 1'b0;
`endif

  assign a_ready = ((state_q == S0) || !b_valid_q || b_ready) && !flush_fire;
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid_q && b_ready;

  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    b_d       = b_q;
    b_valid_d = b_valid_q;

    if (b_fire) b_valid_d = 1'b0;

    if (flush_fire) begin
      if (state_q == S2) b_d = {{LANE_W{1'b0}}, residue_q};
      else               b_d = {{(2*LANE_W){1'b0}}, residue_q[LANE_W-1:0]};
      b_valid_d = 1'b1;
      state_d   = S0;
    end else if (a_fire) begin
      unique case (state_q)
        S0: begin
          residue_d = a;
          state_d   = S2;
        end
        S2: begin
          b_d       = {a[LANE_W-1:0], residue_q};
          residue_d = {{LANE_W{1'b0}}, a[2*LANE_W-1:LANE_W]};
          b_valid_d = 1'b1;
          state_d   = S1;
        end
        S1: begin
          b_d       = {a, residue_q[LANE_W-1:0]};
          b_valid_d = 1'b1;
          state_d   = S0;
        end
        default: state_d = S0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S0;
      residue_q <= '0;
      b_q       <= '0;
      b_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      b_q       <= b_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign b       = b_q;
  assign b_valid = b_valid_q;

endmodule

// File: tb/tb_concatinator.sv
// Self-checking bench for concatinator: vector table, hand sequences, and a
// randomized run against a bit-stream reference model.
module tb_concatinator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] a = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [71:0] b;
  logic        b_valid;
  logic        b_ready = 1'b0;
`ifdef CONCATINATOR_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  concatinator #(.LANE_W(24)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
`ifdef CONCATINATOR_FLUSH_EN
    .flush   (flush),
`endif
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the input is one long little-endian bit stream, and every
  // 72 bits of it become one output word.
  logic [143:0] m_acc;
  int           m_nbits;
  logic [71:0]  m_b;
  logic         m_bvalid;
  int           n_out;

  task automatic model_reset();
    m_acc = '0; m_nbits = 0; m_b = '0; m_bvalid = 1'b0; n_out = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b1; a = 48'hDEAD_BEEF_0123; b_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      a = a + 48'd1;
    end
    a_valid = 1'b0; b_ready = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic model_cycle(input logic av, input logic [47:0] aw, input logic br);
    logic exp_ready;
    logic acc;
    @(negedge clk);
    chk("model_b_valid", {71'd0, b_valid}, {71'd0, m_bvalid});
    if (m_bvalid) chk("model_b", b, m_b);
    a_valid = av; a = aw; b_ready = br;
    #1;
    exp_ready = (m_nbits == 0) || !m_bvalid || br;
    chk("model_a_ready", {71'd0, a_ready}, {71'd0, exp_ready});
    acc = av && exp_ready;
    if (m_bvalid && br) begin
      n_out++;
      m_bvalid = 1'b0;
    end
    if (acc) begin
      m_acc = m_acc | ({96'd0, aw} << m_nbits);
      m_nbits += 48;
      if (m_nbits >= 72) begin
        m_b = m_acc[71:0];
        m_acc = m_acc >> 72;
        m_nbits -= 72;
        m_bvalid = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [47:0] a;
    logic        a_valid;
    logic        b_ready;
    logic        exp_a_ready;
    logic        exp_b_valid;
    logic        chk_b;
    logic [71:0] exp_b;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [63:0] rnd;
    int          xfers;
    logic [71:0] held;

    // Reset while data is applied
    do_reset();
    #1;
    chk("rst_b", b, 72'd0);
    chk("rst_b_valid", {71'd0, b_valid}, 72'd0);
    chk("rst_a_ready", {71'd0, a_ready}, 72'd1);

    tbl[0] = '{48'd70, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 72'd0};
    tbl[1] = '{48'd48, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 72'h000030_000000000046};
    tbl[2] = '{48'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 72'h000000000005_000000};
    tbl[3] = '{48'd9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 72'd0};
    tbl[4] = '{48'd9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 72'd0};
    tbl[5] = '{48'hFFFFFF_AAAAAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 72'hAAAAAA_000000000009};

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = tbl[i].a; a_valid = tbl[i].a_valid; b_ready = tbl[i].b_ready;
      #1;
      chk($sformatf("vec%0d_a_ready", i), {71'd0, a_ready}, {71'd0, tbl[i].exp_a_ready});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_b_valid", i), {71'd0, b_valid}, {71'd0, tbl[i].exp_b_valid});
      if (tbl[i].chk_b) chk($sformatf("vec%0d_b", i), b, tbl[i].exp_b);
    end

    // Backpressure: S1 with an undelivered word, 10 stalled cycles
    do_reset();
    @(negedge clk); a_valid = 1'b1; a = 48'd1; b_ready = 1'b0;
    @(negedge clk); a = 48'd2;
    @(negedge clk); a = 48'd3;
    held = b;
    chk("bp_first_b", held, {24'd2, 48'd1});
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_a_ready", {71'd0, a_ready}, 72'd0);
      chk("bp_b_stable", b, {24'd2, 48'd1});
      chk("bp_b_valid", {71'd0, b_valid}, 72'd1);
      @(negedge clk);
    end
    a_valid = 1'b0; b_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (b_valid && b_ready) xfers++;
      @(negedge clk);
    end
    chk("bp_xfer_once", xfers, 72'd1);
    a_valid = 1'b1; a = 48'd3;
    @(posedge clk); #1;
    chk("bp_next_word", b, 72'h000000000003_000000);
    chk("bp_next_valid", {71'd0, b_valid}, 72'd1);

    // Mid-operation asynchronous reset in S2 with residue ABC and b_valid high
    do_reset();
    @(negedge clk); a_valid = 1'b1; a = 48'd11; b_ready = 1'b0;
    @(negedge clk); a = 48'd12;
    @(negedge clk); b_ready = 1'b1; a = 48'd13;
    @(negedge clk); b_ready = 1'b0; a = 48'hABC;
    @(negedge clk); a_valid = 1'b0;
    chk("mid_pre_b_valid", {71'd0, b_valid}, 72'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_b_valid", {71'd0, b_valid}, 72'd0);
    chk("mid_rst_b", b, 72'd0);
    @(negedge clk); rst_n = 1'b1; a_valid = 1'b1; a = 48'd1; b_ready = 1'b1;
    @(negedge clk); a = 48'd2;
    @(posedge clk); #1;
    chk("mid_after_b", b, {24'd2, 48'd1});
    chk("mid_after_valid", {71'd0, b_valid}, 72'd1);

`ifdef CONCATINATOR_FLUSH_EN
    do_reset();
    @(negedge clk); a_valid = 1'b1; a = 48'd7; b_ready = 1'b1;
    @(negedge clk); a_valid = 1'b1; a = 48'd99; flush = 1'b1;
    #1;
    chk("flush_a_ready", {71'd0, a_ready}, 72'd0);
    @(posedge clk); #1;
    chk("flush_b", b, 72'd7);
    chk("flush_b_valid", {71'd0, b_valid}, 72'd1);
    @(negedge clk); a_valid = 1'b0;
    #1;
    chk("flush_s0_a_ready", {71'd0, a_ready}, 72'd1);
    @(posedge clk); #1;
    chk("flush_s0_noop", {71'd0, b_valid}, 72'd0);
    @(negedge clk); flush = 1'b0;
`endif

    // Streaming 1..30 with full throughput
    do_reset();
    for (int i = 1; i <= 30; i++) model_cycle(1'b1, 48'(i), 1'b1);
    model_cycle(1'b0, 48'd0, 1'b1);
    chk("stream_count", n_out, 72'd20);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rnd = {$urandom, $urandom};
      model_cycle(($urandom % 4) != 0, rnd[47:0], ($urandom % 3) != 0);
    end
    for (int i = 0; i < 3; i++) model_cycle(1'b0, 48'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
